// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA frame-buffer pixel source.
package vga_pkg;

    typedef logic [11:0] pixel_t;

    // 1920x768 timing, front porch / sync / back porch per axis
    localparam int H_SCREEN      = 1920;
    localparam int H_FRONT_PORCH = 88;
    localparam int H_SYNC        = 44;
    localparam int H_BACK_PORCH  = 173;
    localparam int H_PERIOD_DEF  = H_SCREEN + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;

    localparam int V_SCREEN      = 768;
    localparam int V_FRONT_PORCH = 3;
    localparam int V_SYNC        = 6;
    localparam int V_BACK_PORCH  = 30;
    localparam int V_PERIOD_DEF  = V_SCREEN + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;

    localparam pixel_t BG_COLOR_DEF = 12'h000;

    typedef enum logic {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port frame-buffer RAM: one write port, one registered read port, no reset.
module fb_dpram
    import vga_pkg::*;
#(
    parameter int DEPTH = 2 * 160 * 120,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  pixel_t        wr_data,
    input  logic [AW-1:0] rd_addr,
    output pixel_t        rd_data
);

    pixel_t mem [DEPTH];
    pixel_t rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/vga_fb_scaler.sv
// Upscaled, double-buffered 160x120 pixel source for the VGA driver; 2-clock
// latency from pos_x/pos_y to pixel_out, buffer swap at start of vertical blanking.
module vga_fb_scaler
    import vga_pkg::*;
#(
    parameter int     SCREEN_X    = H_SCREEN,
    parameter int     SCREEN_Y    = V_SCREEN,
    parameter int     H_PERIOD    = H_PERIOD_DEF,
    parameter int     V_PERIOD    = V_PERIOD_DEF,
    parameter int     FB_W        = 160,
    parameter int     FB_H        = 120,
    parameter int     SCALE_SHIFT = 2,
    parameter int     WIN_X0      = 0,
    parameter int     WIN_Y0      = 0,
    parameter pixel_t BG_COLOR    = BG_COLOR_DEF,
    parameter int     ADDR_W      = clog2(FB_W * FB_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       pos_x,
    input  logic [11:0]       pos_y,
    output pixel_t            pixel_out,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  pixel_t            wr_data,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              disp_bank,
    output swap_state_t       dbg_swap_state
);

    localparam int FB_PIX = FB_W * FB_H;
    localparam int RAM_AW = clog2(2 * FB_PIX);
    localparam int WIN_W  = FB_W << SCALE_SHIFT;
    localparam int WIN_H  = FB_H << SCALE_SHIFT;

    if ((WIN_X0 + WIN_W > SCREEN_X) || (WIN_Y0 + WIN_H > SCREEN_Y)) begin : g_bad_window
        $error("vga_fb_scaler: image window does not fit in the visible area");
    end

    logic [11:0]       la_x_d, la_x_q;
    logic [11:0]       la_y_d, la_y_q;
    logic              in_win_d, in_win_q;
    logic              in_win_d2_d, in_win_d2_q;
    logic [RAM_AW-1:0] rd_addr_d, rd_addr_q;
    logic [12:0]       x_sum, y_nxt, dx, dy, fb_x, fb_y;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_wr_addr;
    pixel_t            ram_q;

    swap_state_t state_q;
    logic        disp_bank_q;
    logic        swap_ack_q;
    logic        flip_now;

    // Lookahead to the coordinate shown two clocks from now, then window test and fetch address.
    always_comb begin
        x_sum = {1'b0, pos_x} + 13'd2;
        y_nxt = {1'b0, pos_y};
        if (x_sum >= 13'(H_PERIOD)) begin
            x_sum = x_sum - 13'(H_PERIOD);
            y_nxt = y_nxt + 13'd1;
        end
        if (y_nxt == 13'(V_PERIOD)) y_nxt = '0;
        la_x_d = x_sum[11:0];
        la_y_d = y_nxt[11:0];

        dx       = x_sum - 13'(WIN_X0);
        dy       = y_nxt - 13'(WIN_Y0);
        in_win_d = (dx < 13'(WIN_W)) && (dy < 13'(WIN_H));
        fb_x     = dx >> SCALE_SHIFT;
        fb_y     = dy >> SCALE_SHIFT;

        rd_addr_d = '0;
        if (in_win_d) begin
            rd_addr_d = RAM_AW'(fb_y) * RAM_AW'(FB_W) + RAM_AW'(fb_x)
                      + (disp_bank_q ? RAM_AW'(FB_PIX) : RAM_AW'(0));
        end
        in_win_d2_d = in_win_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            la_x_q      <= '0;
            la_y_q      <= '0;
            in_win_q    <= 1'b0;
            in_win_d2_q <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            la_x_q      <= la_x_d;
            la_y_q      <= la_y_d;
            in_win_q    <= in_win_d;
            in_win_d2_q <= in_win_d2_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    // Bank b occupies words [b*FB_PIX, (b+1)*FB_PIX); out-of-range addresses would alias into the other bank.
    assign ram_we      = wr_en && (wr_addr < ADDR_W'(FB_PIX));
    assign ram_wr_addr = RAM_AW'(wr_addr) + (disp_bank_q ? RAM_AW'(0) : RAM_AW'(FB_PIX));

    fb_dpram #(
        .DEPTH (2 * FB_PIX),
        .AW    (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ram_wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr_q),
        .rd_data (ram_q)
    );

    assign flip_now = (la_y_q == 12'(SCREEN_Y)) && (la_x_q == 12'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SWAP_IDLE;
            disp_bank_q <= 1'b0;
            swap_ack_q  <= 1'b0;
        end else begin
            swap_ack_q <= 1'b0;
            case (state_q)
                SWAP_IDLE: begin
                    if (swap_req) state_q <= SWAP_PENDING;
                end
                SWAP_PENDING: begin
                    if (flip_now) begin
                        disp_bank_q <= ~disp_bank_q;
                        swap_ack_q  <= 1'b1;
                        state_q     <= SWAP_IDLE;
                    end
                end
                default: state_q <= SWAP_IDLE;
            endcase
        end
    end

    assign pixel_out      = in_win_d2_q ? ram_q : BG_COLOR;
    assign swap_ack       = swap_ack_q;
    assign disp_bank      = disp_bank_q;
    assign dbg_swap_state = state_q;

endmodule

// File: tb/tb_vga_fb_scaler.sv
// Directed bench for vga_fb_scaler: reset, scaled fetch, window edges, wrap, swap timing, write guard.
module tb_vga_fb_scaler;
    import vga_pkg::*;

    localparam int ADDR_W = 15;
    localparam int HP     = 2225;

    logic              clk = 1'b0;
    logic              rst;
    logic [11:0]       pos_x, pos_y;
    pixel_t            pixel_out;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    pixel_t            wr_data;
    logic              swap_req;
    logic              swap_ack;
    logic              disp_bank;
    swap_state_t       dbg_swap_state;

    logic [15:0] exp_q[$];
    int n_pass = 0;
    int n_total = 0;
    int ack_step, ack_cnt;
    logic disp_at_ack;

    always #5 clk = ~clk;

    vga_fb_scaler dut (
        .clk            (clk),
        .rst            (rst),
        .pos_x          (pos_x),
        .pos_y          (pos_y),
        .pixel_out      (pixel_out),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .swap_req       (swap_req),
        .swap_ack       (swap_ack),
        .disp_bank      (disp_bank),
        .dbg_swap_state (dbg_swap_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    endtask

    // Hold a driver position for two clocks, then compare against the next queued expectation.
    task automatic pix(input string tag, input int x, input int y);
        pos_x = 12'(x);
        pos_y = 12'(y);
        step();
        step();
        chk(tag, 16'(pixel_out), exp_q.pop_front());
    endtask

    // Walk the driver across the end of the last visible line (bounded to 20 clocks).
    task automatic run_to_blank(output int a_step, output int a_cnt, output logic a_disp);
        int px, py;
        a_step = -1;
        a_cnt  = 0;
        a_disp = 1'bx;
        for (int i = 0; i < 20; i++) begin
            px = 2218 + i;
            py = 767;
            if (px >= HP) begin
                px = px - HP;
                py = 768;
            end
            pos_x = 12'(px);
            pos_y = 12'(py);
            step();
            if (swap_ack) begin
                a_cnt++;
                if (a_step < 0) begin
                    a_step = i + 1;
                    a_disp = disp_bank;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        pos_x = 12'd0;
        pos_y = 12'd0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        swap_req = 1'b0;

        // Reset: outputs held at reset values, pipeline stays at background one clock after release
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_pixel", 16'(pixel_out), 16'h000);
            chk("rst_disp", 16'(disp_bank), 16'h0);
            chk("rst_ack", 16'(swap_ack), 16'h0);
        end
        rst = 1'b0;
        step();
        chk("post_rst_pixel", 16'(pixel_out), 16'h000);
        chk("post_rst_state", 16'(dbg_swap_state), 16'(SWAP_IDLE));
        chk("post_rst_ack", 16'(swap_ack), 16'h0);

        // Fill back bank (bank 1) with data = addr[11:0]
        wr_en = 1'b1;
        for (int a = 0; a < 19200; a++) begin
            wr_addr = ADDR_W'(a);
            wr_data = 12'(a);
            step();
        end
        wr_en = 1'b0;

        // Request swap mid-frame, then a second request that must be ignored
        pos_x = 12'd0;
        pos_y = 12'd100;
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        chk("req_state", 16'(dbg_swap_state), 16'(SWAP_PENDING));
        chk("req_no_ack", 16'(swap_ack), 16'h0);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        step();
        chk("req2_state", 16'(dbg_swap_state), 16'(SWAP_PENDING));
        chk("req2_disp", 16'(disp_bank), 16'h0);

        // Flip: ack observed with driver about to present (768,0), bank toggles with it
        run_to_blank(ack_step, ack_cnt, disp_at_ack);
        chk("flip_step", 16'(ack_step), 16'd7);
        chk("flip_cnt", 16'(ack_cnt), 16'd1);
        chk("flip_disp", 16'(disp_at_ack), 16'h1);
        step();
        chk("flip_state", 16'(dbg_swap_state), 16'(SWAP_IDLE));

        // Pixel fetch from bank 1
        exp_q.push_back(16'h0A2); pix("pix_8_4", 8, 4);
        exp_q.push_back(16'h001); pix("pix_3_0", 3, 0);
        exp_q.push_back(16'hAFF); pix("pix_637_479", 637, 479);
        exp_q.push_back(16'h000); pix("edge_638_479", 638, 479);
        exp_q.push_back(16'h000); pix("edge_640_10", 640, 10);
        exp_q.push_back(16'hA60); pix("pix_0_479", 0, 479);
        exp_q.push_back(16'h000); pix("edge_0_480", 0, 480);
        exp_q.push_back(16'h0A0); pix("wrap_2224_5", 2224, 5);
        exp_q.push_back(16'h2C0); pix("wrap_2223_119", 2223, 119);

        // Writes now target bank 0; out-of-range address must not alias into displayed bank 1
        wr_en = 1'b1;
        wr_addr = ADDR_W'(19200);
        wr_data = 12'hFFF;
        step();
        wr_addr = ADDR_W'(162);
        wr_data = 12'h123;
        step();
        wr_en = 1'b0;
        exp_q.push_back(16'h000); pix("guard_0_0", 0, 0);
        exp_q.push_back(16'h0A2); pix("guard_8_4", 8, 4);

        // No request pending: no ack, bank unchanged
        run_to_blank(ack_step, ack_cnt, disp_at_ack);
        chk("idle_cnt", 16'(ack_cnt), 16'd0);
        chk("idle_disp", 16'(disp_bank), 16'h1);

        // Request in the same cycle as the flip condition defers to the next frame
        pos_x = 12'd2223;
        pos_y = 12'd767;
        step();
        swap_req = 1'b1;
        pos_x = 12'd2224;
        step();
        swap_req = 1'b0;
        chk("same_state", 16'(dbg_swap_state), 16'(SWAP_PENDING));
        chk("same_ack", 16'(swap_ack), 16'h0);
        chk("same_disp", 16'(disp_bank), 16'h1);
        run_to_blank(ack_step, ack_cnt, disp_at_ack);
        chk("same_step", 16'(ack_step), 16'd7);
        chk("same_cnt", 16'(ack_cnt), 16'd1);
        chk("same_flip_disp", 16'(disp_at_ack), 16'h0);
        exp_q.push_back(16'h123); pix("bank0_8_4", 8, 4);

        // Reset mid-operation drops the pending swap
        pos_x = 12'd0;
        pos_y = 12'd100;
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        chk("mid_req_state", 16'(dbg_swap_state), 16'(SWAP_PENDING));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_state", 16'(dbg_swap_state), 16'(SWAP_IDLE));
        chk("mid_rst_pixel", 16'(pixel_out), 16'h000);
        run_to_blank(ack_step, ack_cnt, disp_at_ack);
        chk("mid_rst_cnt", 16'(ack_cnt), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
